// File: rtl/aes_key_expansion.sv
// AES-128 key expansion: captures a key on ready and builds one round key per clock
// into a registered 1408-bit schedule, raising done once w0..w43 are all valid.

module aes_sbox (
  input  logic [7:0] value,
  output logic [7:0] sub
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign sub = SBOX[value];

endmodule

module aes_key_expansion (
  input  logic           clk,
  input  logic           rst,
  input  logic           ready,
  input  logic [0:127]   key,
  output logic [0:1407]  schedule,
  output logic           done
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  state_t         state_r, state_s;
  logic [3:0]     round_r, round_s;
  logic [0:1407]  schedule_s;
  logic           done_s;
  logic [0:127]   prev_rk_s;
  logic [0:127]   new_rk_s;
  logic [31:0]    w_a_s, w_b_s, w_c_s, w_d_s;
  logic [31:0]    rot_s, sub_s, temp_s;
  logic [31:0]    w_0_s, w_1_s, w_2_s, w_3_s;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // Select round key r-1 as the source for the round being computed
  always_comb begin
    prev_rk_s = 128'h0;
    case (round_r)
      4'd1:    prev_rk_s = schedule[0:127];
      4'd2:    prev_rk_s = schedule[128:255];
      4'd3:    prev_rk_s = schedule[256:383];
      4'd4:    prev_rk_s = schedule[384:511];
      4'd5:    prev_rk_s = schedule[512:639];
      4'd6:    prev_rk_s = schedule[640:767];
      4'd7:    prev_rk_s = schedule[768:895];
      4'd8:    prev_rk_s = schedule[896:1023];
      4'd9:    prev_rk_s = schedule[1024:1151];
      4'd10:   prev_rk_s = schedule[1152:1279];
      default: prev_rk_s = 128'h0;
    endcase
  end

  assign w_a_s = prev_rk_s[0:31];
  assign w_b_s = prev_rk_s[32:63];
  assign w_c_s = prev_rk_s[64:95];
  assign w_d_s = prev_rk_s[96:127];
  assign rot_s = {w_d_s[23:0], w_d_s[31:24]};

  aes_sbox u_sbox_0 (.value(rot_s[31:24]), .sub(sub_s[31:24]));
  aes_sbox u_sbox_1 (.value(rot_s[23:16]), .sub(sub_s[23:16]));
  aes_sbox u_sbox_2 (.value(rot_s[15:8]),  .sub(sub_s[15:8]));
  aes_sbox u_sbox_3 (.value(rot_s[7:0]),   .sub(sub_s[7:0]));

  assign temp_s   = sub_s ^ {rcon(round_r), 24'h000000};
  assign w_0_s    = w_a_s ^ temp_s;
  assign w_1_s    = w_0_s ^ w_b_s;
  assign w_2_s    = w_1_s ^ w_c_s;
  assign w_3_s    = w_2_s ^ w_d_s;
  assign new_rk_s = {w_0_s, w_1_s, w_2_s, w_3_s};

  // Next-state, round counter and schedule update; ready overrides any expansion
  always_comb begin
    state_s    = state_r;
    round_s    = round_r;
    schedule_s = schedule;
    done_s     = done;
    if (ready) begin
      schedule_s = {key, 1280'h0};
      done_s     = 1'b0;
      round_s    = 4'd1;
      state_s    = EXPAND;
    end else begin
      case (state_r)
        IDLE: begin
          round_s = 4'd0;
        end
        EXPAND: begin
          case (round_r)
            4'd1:    schedule_s[128:255]   = new_rk_s;
            4'd2:    schedule_s[256:383]   = new_rk_s;
            4'd3:    schedule_s[384:511]   = new_rk_s;
            4'd4:    schedule_s[512:639]   = new_rk_s;
            4'd5:    schedule_s[640:767]   = new_rk_s;
            4'd6:    schedule_s[768:895]   = new_rk_s;
            4'd7:    schedule_s[896:1023]  = new_rk_s;
            4'd8:    schedule_s[1024:1151] = new_rk_s;
            4'd9:    schedule_s[1152:1279] = new_rk_s;
            4'd10:   schedule_s[1280:1407] = new_rk_s;
            default: schedule_s = schedule;
          endcase
          if (round_r == 4'd10) begin
            done_s  = 1'b1;
            round_s = 4'd0;
            state_s = IDLE;
          end else if ((round_r == 4'd0) || (round_r > 4'd10)) begin
            // An out-of-range counter cannot be trusted; park without claiming done
            round_s = 4'd0;
            state_s = IDLE;
          end else begin
            round_s = round_r + 4'd1;
          end
        end
        default: begin
          round_s = 4'd0;
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      round_r  <= 4'd0;
      schedule <= 1408'h0;
      done     <= 1'b0;
    end else begin
      state_r  <= state_s;
      round_r  <= round_s;
      schedule <= schedule_s;
      done     <= done_s;
    end
  end

endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed bench for aes_key_expansion: FIPS-197 and zero-key schedules, restart,
// hold, held-high ready and asynchronous reset, checked through a scoreboard queue.

module tb_aes_key_expansion;

  logic          clk;
  logic          rst;
  logic          ready;
  logic [0:127]  key;
  logic [0:1407] schedule;
  logic          done;

  aes_key_expansion dut (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .key      (key),
    .schedule (schedule),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    int           slot;   // -1 selects the done flag
    logic [127:0] val;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  logic [127:0] fips_rk [11];
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  task automatic push_slot(input string tag, input int slot, input logic [127:0] val);
    exp_t e;
    e.tag = tag;
    e.slot = slot;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic push_done(input string tag, input logic d);
    push_slot(tag, -1, {127'h0, d});
  endtask

  // FIPS key schedule state k edges after capture: slots 0..k valid, rest zero
  task automatic push_fips(input string tag, input int k);
    for (int s = 0; s < 11; s++)
      push_slot($sformatf("%s_k%0d_rk%0d", tag, k, s), s, (s <= k) ? fips_rk[s] : 128'h0);
    push_done($sformatf("%s_k%0d_done", tag, k), (k == 10) ? 1'b1 : 1'b0);
  endtask

  task automatic push_all_zero(input string tag);
    for (int s = 0; s < 11; s++)
      push_slot($sformatf("%s_rk%0d", tag, s), s, 128'h0);
    push_done($sformatf("%s_done", tag), 1'b0);
  endtask

  task automatic check_sb();
    exp_t         e;
    logic [127:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.slot < 0) obs = {127'h0, done};
      else            obs = schedule[e.slot*128 +: 128];
      compared++;
      assert (obs === e.val) else begin
        mismatched++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    fips_rk[0]  = FIPS_KEY;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst = 1'b1;
    ready = 1'b0;
    key = 128'h0;
    #1;
    push_all_zero("reset");
    check_sb();
    tick();
    tick();
    rst = 1'b0;
    tick();
    push_all_zero("idle_after_reset");
    check_sb();

    // FIPS-197 vector, single-cycle ready; key scrambled after capture
    key = FIPS_KEY;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    key = {$urandom, $urandom, $urandom, $urandom};
    push_fips("fips", 0);
    check_sb();
    for (int k = 1; k <= 10; k++) begin
      tick();
      push_fips("fips", k);
      check_sb();
    end

    // Finished schedule held while key wanders with ready low
    for (int i = 0; i < 20; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    push_fips("hold", 10);
    check_sb();

    // Restart at T+4 with the zero key
    key = FIPS_KEY;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    for (int k = 1; k <= 3; k++) tick();
    push_fips("pre_restart", 3);
    check_sb();
    key = 128'h0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    key = FIPS_KEY;
    push_all_zero("restart_capture");
    check_sb();
    tick();
    push_slot("zero_rk1", 1, ZERO_RK1);
    push_slot("zero_rk2_pending", 2, 128'h0);
    push_done("zero_k1_done", 1'b0);
    check_sb();
    for (int k = 2; k <= 9; k++) tick();
    push_slot("zero_rk10_pending", 10, 128'h0);
    push_done("zero_k9_done", 1'b0);
    check_sb();
    tick();
    push_slot("zero_rk0", 0, 128'h0);
    push_slot("zero_rk1_final", 1, ZERO_RK1);
    push_slot("zero_rk10", 10, ZERO_RK10);
    push_done("zero_k10_done", 1'b1);
    check_sb();

    // ready held high three edges; only the last captured key counts
    key = 128'h0;
    ready = 1'b1;
    tick();
    push_all_zero("held_cap1");
    check_sb();
    key = 128'hffffffffffffffffffffffffffffffff;
    tick();
    push_slot("held_cap2_rk0", 0, 128'hffffffffffffffffffffffffffffffff);
    push_slot("held_cap2_rk1", 1, 128'h0);
    push_done("held_cap2_done", 1'b0);
    check_sb();
    key = FIPS_KEY;
    tick();
    ready = 1'b0;
    push_fips("held", 0);
    check_sb();
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1 || k == 9 || k == 10) begin
        push_fips("held", k);
        check_sb();
      end
    end

    // Asynchronous reset mid-expansion, then wait in IDLE
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    tick();
    tick();
    push_fips("pre_rst", 3);
    check_sb();
    #2;
    rst = 1'b1;
    #1;
    push_all_zero("async_rst");
    check_sb();
    #3;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    push_all_zero("post_rst_idle");
    check_sb();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
